// File: rtl/pspi_pkg.sv
// Shared types, widths and parity helper for the parity-SPI slave.
package pspi_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned FRAME_BITS = DATA_W_DEF + 1;
    localparam int unsigned PAR_MAX_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } pspi_state_e;

    // Parity bit that makes the whole frame (data + this bit) xor to 'odd'.
    function automatic logic parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/pspi_sync.sv
// Two-flop pin synchronizer with edge strobes; strobes compare stage 2 with its delayed copy.
module pspi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= RST_VAL;
            r_s2   <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_prev;
    assign o_fall  = ~r_s2 & r_prev;

endmodule

// File: rtl/pspi_slave.sv
// Parity-SPI slave (mode 0, MSB first, DATA_W data bits + 1 parity bit), oversampled in clk.
// Optional error counter enabled by defining PSPI_SLAVE_ERR_CNT_EN.
module pspi_slave
    import pspi_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              tx_underrun,
    output logic              frame_abort
`ifdef PSPI_SLAVE_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [7:0]        err_count
`endif
);

    localparam int unsigned FRAME_W = DATA_W + 1;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    logic w_ss_lvl,   w_ss_rise,   w_ss_fall;
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    pspi_sync #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .i_pin(ss_n),
        .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    pspi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_pin(sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    pspi_sync #(.RST_VAL(1'b1)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_pin(mosi),
        .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // Strobes and levels this block has no use for.
    assign w_unused = &{1'b0, w_ss_lvl, w_sclk_lvl, w_mosi_rise, w_mosi_fall};

    pspi_state_e       r_state,    w_state_nxt;
    logic [DATA_W-1:0] r_shift_tx, w_shift_tx_nxt;
    logic [DATA_W-1:0] r_shift_rx, w_shift_rx_nxt;
    logic [CNT_W-1:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_W-1:0] r_tx_buf,   w_tx_buf_nxt;
    logic              r_tx_ready, w_tx_ready_nxt;
    logic              r_miso,     w_miso_nxt;
    logic              r_miso_oe,  w_miso_oe_nxt;
    logic [DATA_W-1:0] r_rx_data,  w_rx_data_nxt;
    logic              r_rx_valid, w_rx_valid_nxt;
    logic              r_rx_perr,  w_rx_perr_nxt;
    logic              r_tx_und,   w_tx_und_nxt;
    logic              r_abort,    w_abort_nxt;
    logic [FRAME_W-1:0] w_tx_word;
    logic [FRAME_W-1:0] w_rx_word;
    logic              w_accept;
`ifdef PSPI_SLAVE_ERR_CNT_EN
    logic [7:0]        r_err_count, w_err_count_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_bit_cnt  <= '0;
            r_tx_buf   <= '0;
            r_tx_ready <= 1'b1;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_tx_und   <= 1'b0;
            r_abort    <= 1'b0;
`ifdef PSPI_SLAVE_ERR_CNT_EN
            r_err_count <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shift_tx <= w_shift_tx_nxt;
            r_shift_rx <= w_shift_rx_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_buf   <= w_tx_buf_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_miso     <= w_miso_nxt;
            r_miso_oe  <= w_miso_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_perr  <= w_rx_perr_nxt;
            r_tx_und   <= w_tx_und_nxt;
            r_abort    <= w_abort_nxt;
`ifdef PSPI_SLAVE_ERR_CNT_EN
            r_err_count <= w_err_count_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_tx_nxt = r_shift_tx;
        w_shift_rx_nxt = r_shift_rx;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_buf_nxt   = r_tx_buf;
        w_tx_ready_nxt = r_tx_ready;
        w_miso_nxt     = r_miso;
        w_miso_oe_nxt  = r_miso_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_rx_perr_nxt  = r_rx_perr;
        w_tx_und_nxt   = 1'b0;
        w_abort_nxt    = 1'b0;

        w_accept  = tx_valid & r_tx_ready;
        w_tx_word = r_tx_ready ? {DATA_W'(0), PARITY_ODD}
                               : {r_tx_buf, parity(PAR_MAX_W'(r_tx_buf), PARITY_ODD)};
        w_rx_word = {r_shift_rx, w_mosi_lvl};

        if (w_accept) begin
            w_tx_buf_nxt = tx_data;
        end

        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt    = SHIFT;
                    w_shift_tx_nxt = w_tx_word[DATA_W-1:0];
                    w_miso_nxt     = w_tx_word[FRAME_W-1];
                    w_miso_oe_nxt  = 1'b1;
                    w_bit_cnt_nxt  = '0;
                    w_tx_und_nxt   = r_tx_ready;
                    w_tx_ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                // ss_n release outranks any sclk edge seen in the same cycle.
                if (w_ss_rise) begin
                    w_state_nxt   = IDLE;
                    w_abort_nxt   = 1'b1;
                    w_miso_oe_nxt = 1'b0;
                    w_miso_nxt    = 1'b0;
                end else if (w_sclk_rise) begin
                    w_shift_rx_nxt = w_rx_word[DATA_W-1:0];
                    w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        w_state_nxt    = DONE;
                        w_rx_data_nxt  = w_rx_word[FRAME_W-1:1];
                        w_rx_perr_nxt  = (^w_rx_word) != PARITY_ODD;
                        w_rx_valid_nxt = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    w_miso_nxt     = r_shift_tx[DATA_W-1];
                    w_shift_tx_nxt = {r_shift_tx[DATA_W-2:0], 1'b0};
                end
            end
            DONE: begin
                if (w_ss_rise) begin
                    w_state_nxt   = IDLE;
                    w_miso_oe_nxt = 1'b0;
                    w_miso_nxt    = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A byte accepted on the frame-start cycle refills the buffer for the next frame.
        if (w_accept) begin
            w_tx_ready_nxt = 1'b0;
        end

`ifdef PSPI_SLAVE_ERR_CNT_EN
        w_err_count_nxt = r_err_count;
        if (err_clr) begin
            w_err_count_nxt = 8'd0;
        end else if (w_rx_valid_nxt && w_rx_perr_nxt && (r_err_count != 8'hFF)) begin
            w_err_count_nxt = r_err_count + 8'd1;
        end
`endif
    end

    assign miso          = r_miso;
    assign miso_oe       = r_miso_oe;
    assign tx_ready      = r_tx_ready;
    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_parity_err = r_rx_perr;
    assign tx_underrun   = r_tx_und;
    assign frame_abort   = r_abort;
`ifdef PSPI_SLAVE_ERR_CNT_EN
    assign err_count     = r_err_count;
`endif

endmodule
